// File: rtl/ext_mem_pkt_arbiter.sv
// Whole-packet scheduler for a single-port external packet memory shared by the enqueue
// writer and the dequeue reader, with a length-descriptor FIFO and free-space accounting.
module ext_mem_pkt_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned PCK_LEN    = 12,
  parameter int unsigned DESC_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          sw_rst,
  input  logic                          wr_req,
  input  logic [PCK_LEN-1:0]            wr_len,
  output logic                          wr_gnt,
  output logic                          wr_reject,
  output logic                          wr_pop,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_req,
  output logic                          rd_gnt,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic [ADDR_WIDTH:0]           free_words,
  output logic [$clog2(DESC_DEPTH):0]   pkt_cnt,
  output logic                          desc_full,
  output logic                          busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned FW_W  = ADDR_WIDTH + 1;
  localparam int unsigned DI_W  = $clog2(DESC_DEPTH);
  localparam int unsigned PC_W  = DI_W + 1;
  localparam int unsigned CMP_W = (PCK_LEN > FW_W) ? PCK_LEN : FW_W;

  typedef enum logic [2:0] {IDLE, WR_BURST, WR_DRAIN, RD_BURST, RD_DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, mem_addr_q, mem_addr_d;
  logic [FW_W-1:0]       free_words_q, free_words_d;
  logic [PC_W-1:0]       pkt_cnt_q, pkt_cnt_d;
  logic [DI_W-1:0]       desc_widx_q, desc_widx_d, desc_ridx_q, desc_ridx_d;
  logic [PCK_LEN-1:0]    len_q, len_d, cnt_q, cnt_d;
  logic                  last_wr_q, last_wr_d;
  logic                  wr_gnt_q, wr_gnt_d, wr_reject_q, wr_reject_d, wr_pop_q, wr_pop_d;
  logic                  rd_gnt_q, rd_gnt_d, mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic                  rd_first_q, rd_first_d, rd_last_q, rd_last_d;
  logic                  out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
  logic                  desc_full_q, desc_full_d, busy_q, busy_d;
  logic                  desc_we;
  logic [PCK_LEN-1:0]    desc_mem_q [DESC_DEPTH];
  logic [CMP_W-1:0]      len_x, free_x;
  logic                  len_ok, wr_elig, rd_elig;

  always_comb begin
    len_x   = CMP_W'(wr_len);
    free_x  = CMP_W'(free_words_q);
    len_ok  = (len_x != '0) && (len_x <= CMP_W'(DEPTH));
    wr_elig = wr_req && len_ok && (len_x <= free_x) && !desc_full_q;
    rd_elig = rd_req && (pkt_cnt_q != '0);
  end

  // Next-state, pointer/accounting and strobe logic
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    free_words_d = free_words_q;
    pkt_cnt_d    = pkt_cnt_q;
    desc_widx_d  = desc_widx_q;
    desc_ridx_d  = desc_ridx_q;
    last_wr_d    = last_wr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    wr_gnt_d     = 1'b0;
    wr_reject_d  = 1'b0;
    rd_gnt_d     = 1'b0;
    wr_pop_d     = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    rd_first_d   = 1'b0;
    rd_last_d    = 1'b0;
    desc_we      = 1'b0;
    out_valid_d  = mem_en_q && !mem_we_q;
    out_sop_d    = out_valid_d && rd_first_q;
    out_eop_d    = out_valid_d && rd_last_q;

    // Each popped word lands on wr_data one cycle later and is written then
    if (wr_pop_q) begin
      mem_en_d   = 1'b1;
      mem_we_d   = 1'b1;
      mem_addr_d = wr_ptr_q;
      wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (wr_req && !len_ok && !wr_reject_q) wr_reject_d = 1'b1;
        if (wr_elig && (!rd_elig || !last_wr_q)) begin
          wr_gnt_d     = 1'b1;
          free_words_d = free_words_q - FW_W'(wr_len);
          len_d        = wr_len;
          cnt_d        = '0;
          last_wr_d    = 1'b1;
          state_d      = WR_BURST;
        end else if (rd_elig) begin
          rd_gnt_d    = 1'b1;
          len_d       = desc_mem_q[desc_ridx_q];
          desc_ridx_d = desc_ridx_q + DI_W'(1);
          pkt_cnt_d   = pkt_cnt_q - PC_W'(1);
          cnt_d       = '0;
          last_wr_d   = 1'b0;
          state_d     = RD_BURST;
        end
      end
      WR_BURST: begin
        if (cnt_q != len_q) begin
          wr_pop_d = 1'b1;
          cnt_d    = cnt_q + PCK_LEN'(1);
        end else begin
          state_d = WR_DRAIN;
        end
      end
      WR_DRAIN: begin
        desc_we     = 1'b1;
        desc_widx_d = desc_widx_q + DI_W'(1);
        pkt_cnt_d   = pkt_cnt_q + PC_W'(1);
        state_d     = IDLE;
      end
      RD_BURST: begin
        if (cnt_q != len_q) begin
          mem_en_d     = 1'b1;
          mem_addr_d   = rd_ptr_q;
          rd_ptr_d     = rd_ptr_q + ADDR_WIDTH'(1);
          free_words_d = free_words_q + FW_W'(1);
          rd_first_d   = (cnt_q == '0);
          rd_last_d    = (cnt_q == len_q - PCK_LEN'(1));
          cnt_d        = cnt_q + PCK_LEN'(1);
        end else begin
          state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Soft reset discards any burst in flight and all stored packets
    if (sw_rst) begin
      state_d      = IDLE;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      free_words_d = FW_W'(DEPTH);
      pkt_cnt_d    = '0;
      desc_widx_d  = '0;
      desc_ridx_d  = '0;
      last_wr_d    = 1'b0;
      len_d        = '0;
      cnt_d        = '0;
      wr_gnt_d     = 1'b0;
      wr_reject_d  = 1'b0;
      rd_gnt_d     = 1'b0;
      wr_pop_d     = 1'b0;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = '0;
      rd_first_d   = 1'b0;
      rd_last_d    = 1'b0;
      desc_we      = 1'b0;
      out_valid_d  = 1'b0;
      out_sop_d    = 1'b0;
      out_eop_d    = 1'b0;
    end

    desc_full_d = (pkt_cnt_d == PC_W'(DESC_DEPTH));
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      free_words_q <= FW_W'(DEPTH);
      pkt_cnt_q    <= '0;
      desc_widx_q  <= '0;
      desc_ridx_q  <= '0;
      last_wr_q    <= 1'b0;
      len_q        <= '0;
      cnt_q        <= '0;
      wr_gnt_q     <= 1'b0;
      wr_reject_q  <= 1'b0;
      rd_gnt_q     <= 1'b0;
      wr_pop_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      rd_first_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      desc_full_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      free_words_q <= free_words_d;
      pkt_cnt_q    <= pkt_cnt_d;
      desc_widx_q  <= desc_widx_d;
      desc_ridx_q  <= desc_ridx_d;
      last_wr_q    <= last_wr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      wr_gnt_q     <= wr_gnt_d;
      wr_reject_q  <= wr_reject_d;
      rd_gnt_q     <= rd_gnt_d;
      wr_pop_q     <= wr_pop_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      rd_first_q   <= rd_first_d;
      rd_last_q    <= rd_last_d;
      out_valid_q  <= out_valid_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      desc_full_q  <= desc_full_d;
      busy_q       <= busy_d;
    end
  end

  // Descriptor storage needs no reset; the indices define what is valid
  always_ff @(posedge clk) begin
    if (desc_we) desc_mem_q[desc_widx_q] <= len_q;
  end

  // Data words pass straight through; their strobes are registered
  assign mem_wdata  = wr_data;
  assign out_data   = mem_rdata;
  assign wr_gnt     = wr_gnt_q;
  assign wr_reject  = wr_reject_q;
  assign wr_pop     = wr_pop_q;
  assign rd_gnt     = rd_gnt_q;
  assign out_valid  = out_valid_q;
  assign out_sop    = out_sop_q;
  assign out_eop    = out_eop_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign free_words = free_words_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign desc_full  = desc_full_q;
  assign busy       = busy_q;

endmodule

// File: doc/ext_mem_pkt_arbiter.md
Name: ext_mem_pkt_arbiter

Overview:
Single-port external packet memory scheduler between the enqueue packet buffer (writer) and the dequeue packet buffer (reader). It moves whole packets only. It grants one side at a time, drives the memory address/enable/write strobes with wrap-around pointers, and records packet lengths in an internal descriptor FIFO. It also tracks free space and stored-packet count, and generates SOP/EOP-framed read data towards the dequeue buffer.

Parameters:
DATA_WIDTH, 32, memory/data word width
ADDR_WIDTH, 14, memory address width; DEPTH = 2**ADDR_WIDTH words
PCK_LEN, 12, packet length field width (length in words)
DESC_DEPTH, 16, descriptor FIFO entries (max stored packets); power of 2

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
sw_rst  in  1  synchronous soft reset, active-high, same effect as rstn
wr_req  in  1  enqueue side holds a complete packet; level, held until wr_gnt
wr_len  in  PCK_LEN  length of that packet in words, stable while wr_req=1
wr_gnt  out  1  one-cycle grant pulse for the writer
wr_reject  out  1  one-cycle pulse: wr_len illegal, packet not granted
wr_pop  out  1  pops one word from the enqueue buffer
wr_data  in  DATA_WIDTH  enqueue word, valid the cycle after wr_pop
rd_req  in  1  dequeue side can accept one full packet
rd_gnt  out  1  one-cycle grant pulse for the reader
out_valid  out  1  out_data valid
out_data  out  DATA_WIDTH  packet word to dequeue buffer
out_sop  out  1  first word of packet, qualified by out_valid
out_eop  out  1  last word of packet, qualified by out_valid
mem_en  out  1  memory access enable
mem_we  out  1  1=write, 0=read; qualified by mem_en
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  write data
mem_rdata  in  DATA_WIDTH  read data, valid 1 cycle after read mem_en
free_words  out  ADDR_WIDTH+1  unreserved memory words
pkt_cnt  out  $clog2(DESC_DEPTH)+1  packets stored and not yet granted to reader
desc_full  out  1  pkt_cnt == DESC_DEPTH
busy  out  1  state != IDLE

Behaviour:
- Reset (rstn low or sw_rst high):
  - state=IDLE; all strobes, grants and out_* are 0.
  - wr_ptr=rd_ptr=0; free_words=DEPTH; pkt_cnt=0; descriptor FIFO empty; last_served=READ.
  - Mid-burst reset aborts the burst. No pops or memory accesses follow. Memory contents are considered discarded.
- States: IDLE, WR_BURST, WR_DRAIN, RD_BURST, RD_DRAIN.
- IDLE reject check: wr_req with wr_len==0 or wr_len>DEPTH gives a wr_reject pulse for one cycle, no grant, and the arbiter stays in IDLE. The writer must drop wr_req.
- IDLE write eligibility: wr_req && legal length && wr_len<=free_words && !desc_full.
- IDLE read eligibility: rd_req && pkt_cnt!=0.
- IDLE arbitration:
  - If only one side is eligible, grant it.
  - If both are eligible, grant the side opposite to last_served (round-robin at packet granularity).
  - If neither is eligible, stay in IDLE.
- Write grant, cycle T:
  - wr_gnt=1; free_words -= wr_len; latch len; cnt=0.
  - Next state WR_BURST; last_served=WRITE.
- WR_BURST:
  - wr_pop=1 for exactly len cycles (T+1..T+len).
  - Each word is written one cycle after its pop (T+2..T+len+1): mem_en=1, mem_we=1, mem_addr=wr_ptr, mem_wdata=wr_data; wr_ptr+1 mod DEPTH.
  - After the last pop, go to WR_DRAIN.
- WR_DRAIN, one cycle:
  - Performs the final write.
  - Pushes len into the descriptor FIFO; pkt_cnt+1; goes to IDLE.
  - The next grant is possible one cycle later.
- Read grant, cycle T:
  - rd_gnt=1; pop descriptor into len; pkt_cnt-1.
  - Next state RD_BURST; last_served=READ.
- RD_BURST:
  - mem_en=1, mem_we=0, mem_addr=rd_ptr for len cycles (T+1..T+len); rd_ptr+1 mod DEPTH.
  - free_words+1 per issued read.
  - After the last read, go to RD_DRAIN.
- Read data output:
  - out_valid=1 with out_data=mem_rdata at T+2..T+len+1.
  - out_sop on the first word, out_eop on the last word. Both are set on the same word when len==1.
- RD_DRAIN, one cycle: emits the final word, then goes to IDLE.
- Write-grant latency: len+2 cycles from grant to IDLE. Read-grant latency is the same.
- Only one burst is active at a time, so no read and write share a cycle. free_words increments (RD_BURST) never coincide with decrements (IDLE grant).
- Wrap-around: pointers roll from DEPTH-1 to 0 mid-packet with no gap. free_words never exceeds DEPTH and never goes negative.
- Full cases:
  - free_words < wr_len: the writer waits; no grant and no reject.
  - desc_full: the writer waits.
- Empty case: pkt_cnt==0 means rd_req is ignored.
- wr_req/rd_req changes during a burst are ignored. Inputs are sampled only in IDLE.

Test Plan:
- ADDR_WIDTH=4: wr_req, wr_len=4 → wr_gnt@T; wr_pop T+1..T+4; writes addr 0..3 at T+2..T+5; pkt_cnt=1, free_words=12. Then rd_req → reads addr 0..3; out_valid 4 cycles with sop on the 1st and eop on the 4th; data matches.
- Wrap: write 10, read 10, write 10 → mem_addr sequence 10..15,0..3; read-back data exact; free_words returns to 16.
- Full: after a 13-word write, free_words=3; wr_len=4 gets no grant. After a 13-word read, grant occurs and free_words=12.
- Contention: wr_req and rd_req both held with pkt_cnt≥1 → grants alternate W,R,W,R starting with WRITE after reset.
- Illegal/limits: wr_len=0 → single wr_reject pulse and no pop. After DESC_DEPTH 1-word packets, desc_full=1 and the next wr_req waits. A 1-word read gives sop=eop=1.
- Reset: sw_rst at the 3rd pop of an 8-word write → no further pop or mem_en; free_words=16, pkt_cnt=0, state IDLE. The same result holds with rstn asserted asynchronously mid RD_BURST.
